y_alu_seq: RTL and testbench
============================

# y_alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. It adds registered outputs, a signed-overflow flag, and multi-cycle shift and multiply operations. The block sits between the register-file read stage and writeback of the multi-cycle datapath. The control FSM issues one operation and waits for the result through a valid/ready handshake.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- a, b  in  WIDTH  operands, two's complement.
- op  in  4  operation code, listed below.
- out_valid  out  1  result held on z/ex/ovf/err.
- out_ready  in  1  consumer accepts result.
- z  out  WIDTH  result.
- ex  out  1  zero flag: z == 0.
- ovf  out  1  signed overflow, ADD/SUB only.
- err  out  1  illegal op code.

## Operation
- Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed; z = {0…,a<b}), 1000 SLL, 1001 SRL, 1010 SRA, 1100 MUL (low WIDTH bits of a*b, unsigned/signed identical).
- Any other op code is illegal: z = 0, ex = 1, err = 1, single-cycle latency.
- FSM states:
  - IDLE: in_ready = 1. A request is accepted on the edge where in_valid & in_ready; operands and op are captured. Single-cycle ops go to DONE; shift/MUL ops go to BUSY.
  - BUSY: in_ready = 0. Shifts move 1 bit per cycle, counting down shamt = b[SHW-1:0]. MUL does one shift-add step per cycle for WIDTH cycles. When the count reaches 0, go to DONE.
  - DONE: out_valid = 1 with z/ex/ovf/err stable. On out_ready, go to IDLE.
- A shift with shamt = 0 goes straight to DONE with z = a.
- SLT is computed as a sign-mux:
  - if a[MSB] != b[MSB], result = a[MSB];
  - otherwise result = (a-b)[MSB].
- ovf is set for ADD when a and b have the same sign and the result sign differs. For SUB it is set when a and b have different signs and the result sign differs from a. ovf is 0 for all other ops.
- The ADD/SUB wrap-around result is kept in z. ovf is informational only and never traps.
- in_valid while not in IDLE is ignored; no queueing.

## Timing
- Reset, applied asynchronously:
  - state = IDLE;
  - z = 0, ex = 0, ovf = 0, err = 0, out_valid = 0;
  - in_ready = 1 from reset deassertion.
- Reset mid-BUSY or mid-DONE abandons the operation; nothing is reported.
- Latency, counted from the accept edge to the edge that raises out_valid:
  - AND/OR/ADD/SUB/SLT/illegal: 1 cycle.
  - Shifts: max(shamt, 1) cycles.
  - MUL: WIDTH cycles.
- DONE holds outputs indefinitely until out_ready. out_ready together with out_valid completes the transfer on that edge. out_valid drops the next cycle and in_ready rises the same cycle.
- Peak throughput: one single-cycle op per 2 cycles. in_ready is decoded from state only and has no combinational path from in_valid or out_ready.
- All outputs are registered except in_ready, which is a state decode.

## Configuration
- YALU_MUL_EN defined: MUL (1100) is implemented as above.
- YALU_MUL_EN undefined: the multiplier datapath is omitted and 1100 is treated as illegal (z = 0, ex = 1, err = 1, 1-cycle latency).
- Shifts are always present.

## Test plan
- Reset and single-cycle ops:
  - Reset, then ADD a=0x7FFFFFFF, b=1, out_ready=1 → out_valid 1 cycle after accept, z=0x80000000, ovf=1, ex=0.
  - Then SUB a=5, b=5 → z=0, ex=1, ovf=0.
- SLT sign-mux: SLT a=0x80000000, b=1 → z=1; SLT a=1, b=0x80000000 → z=0; neither case may be misjudged by the overflow of a-b.
- Shifts: SRA a=0xF0000000, b=4 → out_valid exactly 4 cycles after accept, z=0xFF000000. SLL with b=0 → 1 cycle, z=a.
- Multiply, with YALU_MUL_EN defined: MUL a=0xFFFFFFFF, b=3 → 32 cycles, z=0xFFFFFFFD. Without the macro, same stimulus → 1 cycle, err=1, z=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after out_valid → z stable, in_ready=0, a new in_valid is ignored.
  - Assert rst mid-MUL → out_valid=0 and in_ready=1 immediately; the next request completes normally.

Source files
------------

// File: rtl/y_alu_seq.sv
// y_alu_seq: handshaked sequential ALU with registered results, signed overflow,
// and iterative shifts / shift-add multiply. Define YALU_MUL_EN to build the multiplier.
module y_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             ex,
  output logic             ovf,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_MUL = 4'b1100;

`ifdef YALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] wa, wb, acc;
  logic [SHW-1:0]   cnt;

  logic             accept, finish;
  logic [3:0]       cur_op;
  logic             is_shift, is_mul;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] src_w, src_b, src_acc;
  logic [WIDTH-1:0] step_w, step_b, step_acc;
  logic [WIDTH-1:0] sum, diff;
  logic             slt;
  logic [WIDTH-1:0] fin_z;
  logic             fin_ovf, fin_err;

  assign accept = in_valid & in_ready;
  assign shamt  = b[SHW-1:0];
  assign sum    = a + b;
  assign diff   = a - b;
  // Sign-mux compare: the sign of a-b alone is wrong whenever the subtraction overflows.
  assign slt    = (a[MSB] != b[MSB]) ? a[MSB] : diff[MSB];

  always_comb begin
    cur_op   = (state == IDLE) ? op : op_q;
    is_shift = cur_op inside {OP_SLL, OP_SRL, OP_SRA};
    is_mul   = MUL_EN && (cur_op == OP_MUL);
  end

  // One iteration of shift or shift-add; the first iteration runs on the accept edge.
  always_comb begin
    src_w    = (state == IDLE) ? a  : wa;
    src_b    = (state == IDLE) ? b  : wb;
    src_acc  = (state == IDLE) ? '0 : acc;
    step_b   = src_b >> 1;
    step_acc = src_acc + (src_b[0] ? src_w : '0);
    case (cur_op)
      OP_SLL, OP_MUL: step_w = src_w << 1;
      OP_SRL:         step_w = src_w >> 1;
      OP_SRA:         step_w = {src_w[MSB], src_w[MSB:1]};
      default:        step_w = src_w;
    endcase
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    fin_z   = '0;
    fin_ovf = 1'b0;
    fin_err = 1'b0;
    if (state == BUSY) begin
      fin_z = is_mul ? step_acc : step_w;
    end else begin
      case (op)
        OP_AND: fin_z = a & b;
        OP_OR:  fin_z = a | b;
        OP_ADD: begin
          fin_z   = sum;
          fin_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        end
        OP_SUB: begin
          fin_z   = diff;
          fin_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        end
        OP_SLT:                 fin_z = {{(WIDTH-1){1'b0}}, slt};
        OP_SLL, OP_SRL, OP_SRA: fin_z = (shamt == '0) ? a : step_w;
        default:                fin_err = 1'b1;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) begin
        if (is_mul || (is_shift && shamt > SHW'(1))) state_next = BUSY;
        else                                         state_next = DONE;
      end
      BUSY:    if (cnt == SHW'(1)) state_next = DONE;
      DONE:    if (out_ready)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: in_ready depends on state only.
  always_comb begin
    in_ready = (state == IDLE);
  end

  assign finish = (state != DONE) && (state_next == DONE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      wa        <= '0;
      wb        <= '0;
      acc       <= '0;
      cnt       <= '0;
      z         <= '0;
      ex        <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept || state == BUSY) begin
        wa  <= step_w;
        wb  <= step_b;
        acc <= step_acc;
        if (accept) begin
          op_q <= op;
          cnt  <= is_mul ? SHW'(WIDTH - 1) : shamt - SHW'(1);
        end else begin
          cnt <= cnt - SHW'(1);
        end
      end
      if (finish) begin
        z         <= fin_z;
        ex        <= (fin_z == '0);
        ovf       <= fin_ovf;
        err       <= fin_err;
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_y_alu_seq.sv
// Scoreboard bench for y_alu_seq: directed corner cases plus randomized ops checked
// against an arithmetic reference model; a negedge monitor pops and compares results.
module tb_y_alu_seq;

  localparam int W = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         ex, ovf, err;

  logic rand_ready  = 1'b0;
  logic rr          = 1'b1;
  logic fixed_ready = 1'b1;
  assign out_ready = rand_ready ? rr : fixed_ready;

  y_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .ex(ex), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rr <= ($urandom_range(0, 3) != 0);

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] z;
    logic         ex, ovf, err;
    int           lat;
    int           acc_edge;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] zz, input logic xe, xo, xr, input int l);
    exp_t e;
    e.op = '0; e.z = zz; e.ex = xe; e.ovf = xo; e.err = xr; e.lat = l; e.acc_edge = 0;
    return e;
  endfunction

  // Reference model straight from the operation rules.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    longint      s;
    int          sh;
    logic [63:0] p;
    e.op = o; e.z = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 1; e.acc_edge = 0;
    sh = int'(y[4:0]);
    case (o)
      4'b0000: e.z = x & y;
      4'b0001: e.z = x | y;
      4'b0010: begin
        e.z = x + y;
        s = longint'($signed(x)) + longint'($signed(y));
        e.ovf = (s > MAXS) || (s < MINS);
      end
      4'b0110: begin
        e.z = x - y;
        s = longint'($signed(x)) - longint'($signed(y));
        e.ovf = (s > MAXS) || (s < MINS);
      end
      4'b0111: e.z = {31'b0, ($signed(x) < $signed(y))};
      4'b1000: begin e.z = x << sh; e.lat = (sh == 0) ? 1 : sh; end
      4'b1001: begin e.z = x >> sh; e.lat = (sh == 0) ? 1 : sh; end
      4'b1010: begin e.z = $signed(x) >>> sh; e.lat = (sh == 0) ? 1 : sh; end
`ifdef YALU_MUL_EN
      4'b1100: begin p = {32'b0, x} * {32'b0, y}; e.z = p[31:0]; e.lat = W; end
`endif
      default: e.err = 1'b1;
    endcase
    e.ex = (e.z == '0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("issue_timeout", {63'b0, in_ready}, 64'd1);
      return;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    e.op = o;
    e.acc_edge = cyc + 1;
    last_acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y, model(o, x, y));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: compare each newly presented result against the head of the scoreboard.
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("z op%0h", e.op),   64'(z),   64'(e.z));
        check($sformatf("ex op%0h", e.op),  64'(ex),  64'(e.ex));
        check($sformatf("ovf op%0h", e.op), 64'(ovf), 64'(e.ovf));
        check($sformatf("err op%0h", e.op), 64'(err), 64'(e.err));
        check($sformatf("lat op%0h", e.op), 64'(cyc - e.acc_edge + 1), 64'(e.lat));
      end
    end
    ov_prev <= out_valid && !rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        held;
    int          first_acc;
    logic [3:0]  o;
    logic [W-1:0] x, y;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(negedge clk);
    check("rst_z",         64'(z),         64'd0);
    check("rst_ex",        64'(ex),        64'd0);
    check("rst_ovf",       64'(ovf),       64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // Directed corner cases with hand-computed results.
    issue(4'b0010, 32'h7FFF_FFFF, 32'h1,          mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 1));
    issue(4'b0110, 32'h5,         32'h5,          mk(32'h0,         1'b1, 1'b0, 1'b0, 1));
    issue(4'b0111, 32'h8000_0000, 32'h1,          mk(32'h1,         1'b0, 1'b0, 1'b0, 1));
    issue(4'b0111, 32'h1,         32'h8000_0000,  mk(32'h0,         1'b1, 1'b0, 1'b0, 1));
    issue(4'b0110, 32'h8000_0000, 32'h1,          mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1));
    issue(4'b1010, 32'hF000_0000, 32'h4,          mk(32'hFF00_0000, 1'b0, 1'b0, 1'b0, 4));
    issue(4'b1000, 32'h1234_5678, 32'h0,          mk(32'h1234_5678, 1'b0, 1'b0, 1'b0, 1));
    issue(4'b1001, 32'h8000_0000, 32'h1F,         mk(32'h1,         1'b0, 1'b0, 1'b0, 31));
    issue(4'b1111, 32'hDEAD_BEEF, 32'h1,          mk(32'h0,         1'b1, 1'b0, 1'b1, 1));
`ifdef YALU_MUL_EN
    issue(4'b1100, 32'hFFFF_FFFF, 32'h3,          mk(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32));
`else
    issue(4'b1100, 32'hFFFF_FFFF, 32'h3,          mk(32'h0,         1'b1, 1'b0, 1'b1, 1));
`endif
    wait_drain();

    // Back-to-back single-cycle ops: one accept every 2 cycles.
    issue_m(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    first_acc = last_acc;
    issue_m(4'b0001, 32'h0000_00F0, 32'h0000_0F00);
    check("throughput", 64'(last_acc - first_acc), 64'd2);
    wait_drain();

    // Backpressure: result holds, in_ready stays low, new requests are ignored.
    fixed_ready = 1'b0;
    held = model(4'b0010, 32'h1234_0000, 32'h0000_5678);
    issue(4'b0010, 32'h1234_0000, 32'h0000_5678, held);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = 4'b0001; a = $urandom; b = $urandom;
      @(negedge clk);
      check("bp_z",         64'(z),         64'(held.z));
      check("bp_in_ready",  64'(in_ready),  64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    fixed_ready = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    // Reset in the middle of a (possibly multi-cycle) multiply abandons it.
    issue_m(4'b1100, $urandom, $urandom);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    issue(4'b0010, 32'h3, 32'h4, mk(32'h7, 1'b0, 1'b0, 1'b0, 1));
    wait_drain();

    // Randomized ops with random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 1) == 0) y = y & 32'h7;
      issue_m(o, x, y);
    end
    wait_drain();
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
